// File: rtl/raptorv_pkg.sv
// Shared types for the core pipeline control: sequencer state, control bundle, reg-file constants.
// No logic; no latency; no backpressure.
package raptorv_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic id_flush;
        logic ex_stall;
        logic ex_flush;
        logic mem_stall;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard sources from the pipe and stall/flush controls back to it.
// Master is the datapath side, slave is the sequencer; purely wires, no latency.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             if_busy;
    logic             mem_busy;
    logic             if_stall;
    logic             id_stall;
    logic             id_flush;
    logic             ex_stall;
    logic             ex_flush;
    logic             mem_stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
               ex_redirect, if_busy, mem_busy,
        input  if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
               ex_redirect, if_busy, mem_busy,
        output if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use compare between the instruction in ID and a load in EX.
// Combinational, zero latency; no backpressure of its own.
module hazard_detect
    import raptorv_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    // x0 is hardwired, so a load targeting it never produces a dependency
    assign hazard  = ex_is_load && (ex_rd != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe plus a saturating stall-cycle counter.
// Outputs are combinational from state and inputs; mem_busy freezes the whole pipe.
module pipeline_ctrl
    import raptorv_pkg::*;
#(
    parameter int REDIR_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst_l,
    pipeline_ctrl_if.slave  ctrl
);

    localparam int RW = (REDIR_CYCLES < 1) ? 1 : $clog2(REDIR_CYCLES + 1);

    ctrl_state_t      state_q, state_d;
    logic [RW-1:0]    redir_cnt_q, redir_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    ctrl_out_t        ctl;
    logic             hazard;

    hazard_detect u_hazard (
        .id_rs1      (ctrl.id_rs1),
        .id_rs2      (ctrl.id_rs2),
        .id_rs1_used (ctrl.id_rs1_used),
        .id_rs2_used (ctrl.id_rs2_used),
        .ex_rd       (ctrl.ex_rd),
        .ex_is_load  (ctrl.ex_is_load),
        .hazard      (hazard)
    );

    always_comb begin
        ctl         = '0;
        state_d     = state_q;
        redir_cnt_d = redir_cnt_q;
        if (!rst_l) begin
            ctl.id_flush = 1'b1;
            ctl.ex_flush = 1'b1;
        end else if (ctrl.mem_busy) begin
            // Full freeze; a pending redirect is picked up once memory is done
            ctl.if_stall  = 1'b1;
            ctl.id_stall  = 1'b1;
            ctl.ex_stall  = 1'b1;
            ctl.mem_stall = 1'b1;
        end else if (ctrl.ex_redirect) begin
            ctl.id_flush = 1'b1;
            ctl.ex_flush = 1'b1;
            if (REDIR_CYCLES == 0) begin
                state_d = RUN;
            end else begin
                state_d     = REDIR;
                redir_cnt_d = RW'(REDIR_CYCLES);
            end
        end else if (state_q == REDIR) begin
            ctl.id_flush = 1'b1;
            if (redir_cnt_q <= RW'(1)) begin
                state_d     = RUN;
                redir_cnt_d = '0;
            end else begin
                redir_cnt_d = redir_cnt_q - RW'(1);
            end
        end else if (hazard) begin
            ctl.if_stall = 1'b1;
            ctl.id_stall = 1'b1;
            ctl.ex_flush = 1'b1;
        end else if (ctrl.if_busy) begin
            ctl.if_stall = 1'b1;
            ctl.id_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctl.if_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= REDIR;
            redir_cnt_q <= RW'(REDIR_CYCLES);
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl.if_stall  = ctl.if_stall;
    assign ctrl.id_stall  = ctl.id_stall;
    assign ctrl.id_flush  = ctl.id_flush;
    assign ctrl.ex_stall  = ctl.ex_stall;
    assign ctrl.ex_flush  = ctl.ex_flush;
    assign ctrl.mem_stall = ctl.mem_stall;
    assign ctrl.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: instance A (REDIR_CYCLES=1, 32-bit counter), instance B (REDIR_CYCLES=2, 3-bit counter).
// Output vectors are packed {if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall}.
module tb_pipeline_ctrl;

    logic clk;
    logic rst_l;
    int   n_vec;
    int   n_err;

    pipeline_ctrl_if #(.CNT_W(32)) a_if ();
    pipeline_ctrl_if #(.CNT_W(3))  b_if ();

    pipeline_ctrl #(.REDIR_CYCLES(1), .CNT_W(32)) dut_a (
        .clk   (clk),
        .rst_l (rst_l),
        .ctrl  (a_if)
    );

    pipeline_ctrl #(.REDIR_CYCLES(2), .CNT_W(3)) dut_b (
        .clk   (clk),
        .rst_l (rst_l),
        .ctrl  (b_if)
    );

    logic [5:0] outs_a;
    logic [5:0] outs_b;
    assign outs_a = {a_if.if_stall, a_if.id_stall, a_if.id_flush,
                     a_if.ex_stall, a_if.ex_flush, a_if.mem_stall};
    assign outs_b = {b_if.if_stall, b_if.id_stall, b_if.id_flush,
                     b_if.ex_stall, b_if.ex_flush, b_if.mem_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_if.id_rs1 = '0; a_if.id_rs2 = '0; a_if.id_rs1_used = 0; a_if.id_rs2_used = 0;
        a_if.ex_rd = '0; a_if.ex_is_load = 0; a_if.ex_redirect = 0;
        a_if.if_busy = 0; a_if.mem_busy = 0;
        b_if.id_rs1 = '0; b_if.id_rs2 = '0; b_if.id_rs1_used = 0; b_if.id_rs2_used = 0;
        b_if.ex_rd = '0; b_if.ex_is_load = 0; b_if.ex_redirect = 0;
        b_if.if_busy = 0; b_if.mem_busy = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_l = 1'b0;
        idle_inputs();
        tick();
        tick();

        // In reset: both flushes, no stalls, counter clear
        chk("rst_a_out", 32'(outs_a), 32'b001010);
        chk("rst_b_out", 32'(outs_b), 32'b001010);
        chk("rst_a_cnt", a_if.stall_cnt, 32'd0);

        // Release: A flushes ID one cycle, B two cycles
        rst_l = 1'b1;
        #1;
        chk("rel_a", 32'(outs_a), 32'b001000);
        chk("rel_b", 32'(outs_b), 32'b001000);
        tick();
        chk("run_a", 32'(outs_a), 32'b000000);
        chk("rel_b2", 32'(outs_b), 32'b001000);
        tick();
        chk("run_b", 32'(outs_b), 32'b000000);

        // Load-use on rs2
        a_if.ex_is_load = 1; a_if.ex_rd = 5'd5; a_if.id_rs2 = 5'd5; a_if.id_rs2_used = 1;
        #1;
        chk("lu_rs2", 32'(outs_a), 32'b110010);
        tick();
        a_if.ex_is_load = 0; a_if.ex_rd = 5'd0;
        #1;
        chk("lu_after", 32'(outs_a), 32'b000000);
        chk("lu_cnt", a_if.stall_cnt, 32'd1);
        a_if.ex_is_load = 1; a_if.ex_rd = 5'd0; a_if.id_rs2 = 5'd0;
        #1;
        chk("lu_x0", 32'(outs_a), 32'b000000);
        a_if.ex_rd = 5'd7; a_if.id_rs1 = 5'd7; a_if.id_rs1_used = 0; a_if.id_rs2 = 5'd5;
        #1;
        chk("lu_unused", 32'(outs_a), 32'b000000);
        a_if.id_rs1_used = 1;
        #1;
        chk("lu_rs1", 32'(outs_a), 32'b110010);

        // Redirect beats load-use
        a_if.ex_redirect = 1;
        #1;
        chk("redir_wins", 32'(outs_a), 32'b001010);
        tick();
        a_if.ex_redirect = 0; a_if.ex_is_load = 0; a_if.id_rs1_used = 0; a_if.id_rs2_used = 0;
        #1;
        chk("redir_fl", 32'(outs_a), 32'b001000);
        chk("redir_cnt", a_if.stall_cnt, 32'd1);
        tick();
        chk("redir_done", 32'(outs_a), 32'b000000);

        // Memory freeze hides a coincident redirect for 3 cycles
        a_if.mem_busy = 1; a_if.ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze", 32'(outs_a), 32'b110101);
            tick();
        end
        a_if.mem_busy = 0;
        #1;
        chk("late_redir", 32'(outs_a), 32'b001010);
        chk("frz_cnt", a_if.stall_cnt, 32'd4);
        tick();
        a_if.ex_redirect = 0;
        #1;
        chk("late_redir2", 32'(outs_a), 32'b001000);
        tick();
        chk("late_run", 32'(outs_a), 32'b000000);

        // Fetch wait: NOP into ID, EX/MEM keep going
        a_if.if_busy = 1;
        #1;
        chk("if_busy", 32'(outs_a), 32'b101000);
        tick();
        a_if.if_busy = 0;
        #1;
        chk("ifb_cnt", a_if.stall_cnt, 32'd5);

        // B: redirect pulse with two extra flush cycles
        b_if.ex_redirect = 1;
        #1;
        chk("b_redir", 32'(outs_b), 32'b001010);
        tick();
        b_if.ex_redirect = 0;
        #1;
        chk("b_r1", 32'(outs_b), 32'b001000);
        tick();
        chk("b_r2", 32'(outs_b), 32'b001000);
        tick();
        chk("b_run", 32'(outs_b), 32'b000000);

        // B: 3-bit counter reaches 6, then saturates at 7
        b_if.if_busy = 1;
        repeat (6) tick();
        chk("b_cnt6", 32'(b_if.stall_cnt), 32'd6);
        tick();
        chk("b_cnt7", 32'(b_if.stall_cnt), 32'd7);
        tick();
        tick();
        chk("b_sat", 32'(b_if.stall_cnt), 32'd7);
        chk("b_sat_out", 32'(outs_b), 32'b101000);
        b_if.if_busy = 0;

        // Asynchronous reset mid-operation
        a_if.if_busy = 1;
        tick();
        chk("pre_arst_cnt", a_if.stall_cnt, 32'd6);
        rst_l = 1'b0;
        #1;
        chk("arst_out", 32'(outs_a), 32'b001010);
        chk("arst_cnt", a_if.stall_cnt, 32'd0);
        chk("arst_b_cnt", 32'(b_if.stall_cnt), 32'd0);
        a_if.if_busy = 0;
        rst_l = 1'b1;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
